// File: rtl/hilo_mdu_ctrl.sv
// HI/LO write sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO: 1-cycle multiply, 32-iteration restoring divide.
// Latency: mult/mthi/mtlo write 1 cycle after accept; divide writes 33 cycles after accept (1 cycle for divide-by-zero).
// Backpressure: stall_o holds IF..EX while a divide is being accepted or running; flush cancels everything.
module hilo_mdu_ctrl #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_o,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem_q, quo_q, dvsr_q;
    logic        neg_quo, neg_rem;

    logic        accept, is_div, last_iter;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] a_ext, b_ext, prod;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_nxt, quo_nxt;

    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign accept    = (state == IDLE) && op_valid && !flush && (op >= OP_MULT) && (op <= OP_MTLO);
    assign last_iter = (cnt == 6'(DIV_ITER - 1));

    // Low 64 bits of the extended-operand product are correct for both signed and unsigned
    assign a_ext = (op == OP_MULT) ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
    assign b_ext = (op == OP_MULT) ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
    assign prod  = a_ext * b_ext;

    assign a_neg = (op == OP_DIV) && src_a[31];
    assign b_neg = (op == OP_DIV) && src_b[31];
    assign a_mag = a_neg ? (32'd0 - src_a) : src_a;
    assign b_mag = b_neg ? (32'd0 - src_b) : src_b;

    // Restoring step: shift the next dividend bit into the partial remainder and try to subtract
    assign trial   = {rem_q, quo_q[31]} - {1'b0, dvsr_q};
    assign q_bit   = !trial[32];
    assign rem_nxt = q_bit ? trial[31:0] : {rem_q[30:0], quo_q[31]};
    assign quo_nxt = {quo_q[30:0], q_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            IDLE:    if (accept && is_div) state_nxt = (src_b == 32'd0) ? DONE : DIV_RUN;
            DIV_RUN: if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
        stall_o = rst && !flush && (((state == IDLE) && op_valid && is_div) || (state == DIV_RUN));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
            hi_wdata <= 32'd0;
            lo_wdata <= 32'd0;
        end else begin
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    hi_we    <= 1'b1;
                                    lo_we    <= 1'b1;
                                    hi_wdata <= prod[63:32];
                                    lo_wdata <= prod[31:0];
                                end
                                OP_MTHI: begin
                                    hi_we    <= 1'b1;
                                    hi_wdata <= src_a;
                                end
                                OP_MTLO: begin
                                    lo_we    <= 1'b1;
                                    lo_wdata <= src_a;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (src_b == 32'd0) begin
                                        hi_we    <= 1'b1;
                                        lo_we    <= 1'b1;
                                        hi_wdata <= src_a;
                                        lo_wdata <= 32'hFFFF_FFFF;
                                    end else begin
                                        cnt     <= 6'd0;
                                        rem_q   <= 32'd0;
                                        quo_q   <= a_mag;
                                        dvsr_q  <= b_mag;
                                        neg_quo <= a_neg ^ b_neg;
                                        neg_rem <= a_neg;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    DIV_RUN: begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt   <= cnt + 6'd1;
                        if (last_iter) begin
                            hi_we    <= 1'b1;
                            lo_we    <= 1'b1;
                            lo_wdata <= neg_quo ? (32'd0 - quo_nxt) : quo_nxt;
                            hi_wdata <= neg_rem ? (32'd0 - rem_nxt) : rem_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
